// File: rtl/intersection_phase_controller_pkg.sv
// Shared lamp codes, controller state encoding and a width helper
// for intersection_phase_controller and its seconds prescaler.
package intersection_phase_controller_pkg;

    localparam logic [1:0] LAMP_RED    = 2'b00;
    localparam logic [1:0] LAMP_GREEN  = 2'b01;
    localparam logic [1:0] LAMP_YELLOW = 2'b10;

    typedef enum logic [1:0] {
        ST_GREEN   = 2'b00,
        ST_YELLOW  = 2'b01,
        ST_ALL_RED = 2'b10
    } phase_state_t;

    // Bits needed to index n items, never below 1 so single-bit fields stay legal.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(n)) w++;
        return w;
    endfunction

endpackage

// File: rtl/intersection_phase_controller_sec_prescaler.sv
// Seconds prescaler: divides clk by CLK_PER_SEC and flags the last cycle of
// each second; a synchronous clear restarts the second from zero.
module intersection_phase_controller_sec_prescaler
    import intersection_phase_controller_pkg::*;
#(
    parameter int unsigned CLK_PER_SEC = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic sec_tick
);

    localparam int unsigned   CW   = clog2_min1(CLK_PER_SEC);
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_SEC - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign sec_tick = (count == LAST);

endmodule

// File: rtl/intersection_phase_controller.sv
// Multi-phase intersection controller sequencing GREEN -> YELLOW -> ALL_RED with
// demand latching, min/max green, gap-out and round-robin service. Optional macro: PREEMPT_EN.
module intersection_phase_controller
    import intersection_phase_controller_pkg::*;
#(
    parameter int unsigned NUM_PHASES     = 2,
    parameter int unsigned CLK_PER_SEC    = 100,
    parameter int unsigned MAIN_MIN_GREEN = 20,
    parameter int unsigned MAIN_MAX_GREEN = 40,
    parameter int unsigned SIDE_MIN_GREEN = 5,
    parameter int unsigned SIDE_MAX_GREEN = 10,
    parameter int unsigned YELLOW_TIME    = 3,
    parameter int unsigned ALL_RED_TIME   = 1,
    parameter int unsigned SEC_W          = 12,
    localparam int unsigned PW            = clog2_min1(NUM_PHASES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_PHASES-1:0]   demand,
    input  logic                    congestion,
`ifdef PREEMPT_EN
    input  logic                    preempt,
    input  logic [PW-1:0]           preempt_phase,
`endif
    output logic [2*NUM_PHASES-1:0] lights,
    output logic [PW-1:0]           active_phase,
    output logic [1:0]              fsm_state,
    output logic [SEC_W-1:0]        sec_elapsed
);

    localparam logic [SEC_W-1:0] T_MAIN_MIN = SEC_W'(MAIN_MIN_GREEN);
    localparam logic [SEC_W-1:0] T_MAIN_MAX = SEC_W'(MAIN_MAX_GREEN);
    localparam logic [SEC_W-1:0] T_SIDE_MIN = SEC_W'(SIDE_MIN_GREEN);
    localparam logic [SEC_W-1:0] T_SIDE_MAX = SEC_W'(SIDE_MAX_GREEN);
    localparam logic [SEC_W-1:0] T_YELLOW   = SEC_W'(YELLOW_TIME);
    localparam logic [SEC_W-1:0] T_ALL_RED  = SEC_W'(ALL_RED_TIME);
    localparam logic [2*NUM_PHASES-1:0] LIGHTS_RESET = (2*NUM_PHASES)'(LAMP_GREEN);

    phase_state_t            state, state_nx;
    logic [PW-1:0]           next_phase, next_nx, active_nx, target, rr_pick;
    logic [NUM_PHASES-1:0]   pending;
    logic [2*NUM_PHASES-1:0] lights_nx;
    logic [SEC_W-1:0]        sec_eff;
    logic                    sec_tick, sec_clear, enter_green, yield, go_yellow;
    logic                    pre_valid, force_pre, hold_pre, restart;
    logic [PW-1:0]           pre_phase;

`ifdef PREEMPT_EN
    logic hold_prev;

    assign pre_valid = preempt && (32'(preempt_phase) < NUM_PHASES);
    assign pre_phase = preempt_phase;
    assign force_pre = pre_valid && (preempt_phase != active_phase);
    assign hold_pre  = pre_valid && (preempt_phase == active_phase) && (state == ST_GREEN);
    // Dropping preempt while its phase is green restarts timing so normal min/max apply afresh.
    assign restart   = hold_prev && !hold_pre && (state == ST_GREEN);

    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_prev <= 1'b0;
        end else begin
            hold_prev <= hold_pre;
        end
    end
`else
    assign pre_valid = 1'b0;
    assign pre_phase = '0;
    assign force_pre = 1'b0;
    assign hold_pre  = 1'b0;
    assign restart   = 1'b0;
`endif

    intersection_phase_controller_sec_prescaler #(
        .CLK_PER_SEC(CLK_PER_SEC)
    ) u_sec_prescaler (
        .clk     (clk),
        .rst     (rst),
        .clear   (sec_clear),
        .sec_tick(sec_tick)
    );

    // Seconds value as it stands after this edge, so thresholds land on exact N*CLK_PER_SEC cycles.
    assign sec_eff   = (sec_tick && (sec_elapsed != '1)) ? sec_elapsed + 1'b1 : sec_elapsed;
    assign sec_clear = (state_nx != state) || restart;
    assign fsm_state = state;

    // Descending scan: the last hit written is the nearest pending phase after active_phase.
    always_comb begin
        rr_pick = '0;
        for (int unsigned k = NUM_PHASES - 1; k >= 1; k--) begin
            if (pending[(32'(active_phase) + k) % NUM_PHASES]) begin
                rr_pick = PW'((32'(active_phase) + k) % NUM_PHASES);
            end
        end
    end

    always_comb begin
        if (active_phase == '0) begin
            yield = (|pending[NUM_PHASES-1:1]) &&
                    (((sec_eff >= T_MAIN_MIN) && !congestion) || (sec_eff >= T_MAIN_MAX));
        end else begin
            yield = (sec_eff >= T_SIDE_MAX) ||
                    ((sec_eff >= T_SIDE_MIN) && (!demand[active_phase] || congestion));
        end
        go_yellow = (state == ST_GREEN) && ((yield && !hold_pre) || force_pre);
        target    = force_pre ? pre_phase : rr_pick;

        state_nx  = state;
        active_nx = active_phase;
        next_nx   = next_phase;
        case (state)
            ST_GREEN: begin
                if (go_yellow) begin
                    state_nx = ST_YELLOW;
                    next_nx  = target;
                end
            end
            ST_YELLOW: begin
                if (pre_valid) next_nx = pre_phase;
                if (sec_eff >= T_YELLOW) begin
                    if (ALL_RED_TIME == 0) begin
                        state_nx  = ST_GREEN;
                        active_nx = next_nx;
                    end else begin
                        state_nx = ST_ALL_RED;
                    end
                end
            end
            ST_ALL_RED: begin
                if (pre_valid) next_nx = pre_phase;
                if (sec_eff >= T_ALL_RED) begin
                    state_nx  = ST_GREEN;
                    active_nx = next_nx;
                end
            end
            default: begin
                state_nx  = ST_GREEN;
                active_nx = '0;
            end
        endcase
        enter_green = (state != ST_GREEN) && (state_nx == ST_GREEN);

        lights_nx = '0;
        if (state_nx == ST_GREEN) begin
            lights_nx[2*int'(active_nx) +: 2] = LAMP_GREEN;
        end else if (state_nx == ST_YELLOW) begin
            lights_nx[2*int'(active_nx) +: 2] = LAMP_YELLOW;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_GREEN;
            active_phase <= '0;
            next_phase   <= '0;
            pending      <= '0;
            lights       <= LIGHTS_RESET;
        end else begin
            state        <= state_nx;
            active_phase <= active_nx;
            next_phase   <= next_nx;
            lights       <= lights_nx;
            for (int unsigned i = 0; i < NUM_PHASES; i++) begin
                if (enter_green && (active_nx == PW'(i))) begin
                    pending[i] <= 1'b0;
                end else if (!((state == ST_GREEN) && (active_phase == PW'(i)))) begin
                    pending[i] <= pending[i] | demand[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || sec_clear) begin
            sec_elapsed <= '0;
        end else if (sec_tick && (sec_elapsed != '1)) begin
            sec_elapsed <= sec_elapsed + 1'b1;
        end
    end

endmodule

// File: tb/tb_intersection_phase_controller.sv
// Scoreboard bench for intersection_phase_controller (3 phases, 4 clk/s): expected
// phase/state changes are queued with their cycle and matched as the DUT changes.
module tb_intersection_phase_controller;

    localparam int unsigned NP   = 3;
    localparam int unsigned CPS  = 4;
    localparam logic [1:0]  S_G  = 2'b00;
    localparam logic [1:0]  S_Y  = 2'b01;
    localparam logic [1:0]  S_AR = 2'b10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  demand = '0;
    logic        congestion = 1'b0;
    logic [5:0]  lights;
    logic [1:0]  active_phase;
    logic [1:0]  fsm_state;
    logic [11:0] sec_elapsed;
`ifdef PREEMPT_EN
    logic        preempt = 1'b0;
    logic [1:0]  preempt_phase = '0;
`endif

    intersection_phase_controller #(
        .NUM_PHASES (NP),
        .CLK_PER_SEC(CPS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .demand       (demand),
        .congestion   (congestion),
`ifdef PREEMPT_EN
        .preempt      (preempt),
        .preempt_phase(preempt_phase),
`endif
        .lights       (lights),
        .active_phase (active_phase),
        .fsm_state    (fsm_state),
        .sec_elapsed  (sec_elapsed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  st;
        logic [1:0]  ph;
        logic [5:0]  lt;
        int unsigned at;
    } ev_t;

    ev_t         exp_q[$];
    int unsigned cyc = 0;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned safety_bad = 0;
    int unsigned lit_cnt;
    logic [3:0]  prev = 4'b0000;
    int unsigned t0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic logic [5:0] lamp_word(input logic [1:0] st, input logic [1:0] ph);
        logic [5:0] w;
        w = '0;
        if (st == S_G)      w[2*ph +: 2] = 2'b01;
        else if (st == S_Y) w[2*ph +: 2] = 2'b10;
        return w;
    endfunction

    task automatic expect_ev(input logic [1:0] st, input logic [1:0] ph, input int unsigned at);
        ev_t e;
        e.st = st;
        e.ph = ph;
        e.lt = lamp_word(st, ph);
        e.at = at;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic finish_scn(input int unsigned c);
        wait_until(c);
        check("events_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic do_reset(output int unsigned t);
        @(negedge clk);
        rst = 1'b0;
        demand = '0;
        congestion = 1'b0;
`ifdef PREEMPT_EN
        preempt = 1'b0;
`endif
        @(negedge clk);
        rst = 1'b1;
        t = cyc;
    endtask

    // Monitor: safety every cycle, scoreboard match on every state/phase change.
    always @(negedge clk) begin
        lit_cnt = 0;
        for (int i = 0; i < int'(NP); i++) begin
            if (lights[2*i +: 2] != 2'b00) lit_cnt++;
            if (lights[2*i +: 2] == 2'b11) safety_bad++;
        end
        if (lit_cnt > 1) safety_bad++;
        if ({fsm_state, active_phase} != prev) begin
            check("event_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                ev_t e;
                e = exp_q.pop_front();
                check("ev_state", fsm_state, e.st);
                check("ev_phase", active_phase, e.ph);
                check("ev_lights", lights, e.lt);
                check("ev_cycle", cyc, e.at);
            end
            prev = {fsm_state, active_phase};
        end
    end

    initial begin
        // Reset values and rest-in-green with saturating seconds.
        do_reset(t0);
        check("rst_lights", lights, 6'b000001);
        check("rst_phase", active_phase, 0);
        check("rst_state", fsm_state, S_G);
        check("rst_sec", sec_elapsed, 0);
        wait_until(t0 + 200 * CPS);
        check("rest_sec_200", sec_elapsed, 200);
        wait_until(t0 + 4100 * CPS);
        check("rest_sec_sat", sec_elapsed, 12'hFFF);
        check("rest_lights", lights, 6'b000001);
        finish_scn(t0 + 4100 * CPS + 1);

        // Side demand pulse: phase 0 min green, yellow, all-red, phase 2, gap-out, back to 0.
        do_reset(t0);
        expect_ev(S_Y, 0, t0 + 80);
        expect_ev(S_AR, 0, t0 + 92);
        expect_ev(S_G, 2, t0 + 96);
        expect_ev(S_Y, 2, t0 + 116);
        expect_ev(S_AR, 2, t0 + 128);
        expect_ev(S_G, 0, t0 + 132);
        wait_until(t0 + 8);
        demand = 3'b100;
        @(negedge clk);
        demand = '0;
        finish_scn(t0 + 140);

        // Congestion holds main to max green; side held demand runs to side max.
        do_reset(t0);
        congestion = 1'b1;
        demand = 3'b010;
        expect_ev(S_Y, 0, t0 + 160);
        expect_ev(S_AR, 0, t0 + 172);
        expect_ev(S_G, 1, t0 + 176);
        expect_ev(S_Y, 1, t0 + 216);
        expect_ev(S_AR, 1, t0 + 228);
        expect_ev(S_G, 0, t0 + 232);
        wait_until(t0 + 161);
        congestion = 1'b0;
        wait_until(t0 + 216);
        demand = '0;
        finish_scn(t0 + 240);

        // Side phase gap-out after demand drops at 3 s.
        do_reset(t0);
        demand = 3'b010;
        expect_ev(S_Y, 0, t0 + 80);
        expect_ev(S_AR, 0, t0 + 92);
        expect_ev(S_G, 1, t0 + 96);
        expect_ev(S_Y, 1, t0 + 116);
        expect_ev(S_AR, 1, t0 + 128);
        expect_ev(S_G, 0, t0 + 132);
        wait_until(t0 + 108);
        check("side_sec_3", sec_elapsed, 3);
        demand = '0;
        finish_scn(t0 + 140);

        // Two latched demands: round robin 1 -> 2 -> 0.
        do_reset(t0);
        wait_until(t0 + 4);
        demand = 3'b110;
        @(negedge clk);
        demand = '0;
        expect_ev(S_Y, 0, t0 + 80);
        expect_ev(S_AR, 0, t0 + 92);
        expect_ev(S_G, 1, t0 + 96);
        expect_ev(S_Y, 1, t0 + 116);
        expect_ev(S_AR, 1, t0 + 128);
        expect_ev(S_G, 2, t0 + 132);
        expect_ev(S_Y, 2, t0 + 152);
        expect_ev(S_AR, 2, t0 + 164);
        expect_ev(S_G, 0, t0 + 168);
        finish_scn(t0 + 176);

        // One-cycle reset in the middle of yellow aborts straight to phase 0 green.
        do_reset(t0);
        wait_until(t0 + 4);
        demand = 3'b010;
        @(negedge clk);
        demand = '0;
        expect_ev(S_Y, 0, t0 + 80);
        expect_ev(S_G, 0, t0 + 85);
        wait_until(t0 + 84);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("midrst_lights", lights, 6'b000001);
        check("midrst_sec", sec_elapsed, 0);
        check("midrst_state", fsm_state, S_G);
        wait_until(t0 + 185);
        check("midrst_still_green", {fsm_state, active_phase}, {S_G, 2'd0});
        check("midrst_sec_25", sec_elapsed, 25);
        finish_scn(t0 + 186);

`ifdef PREEMPT_EN
        // Preempt at 3 s of main green, hold phase 1 past max green, release and gap out.
        do_reset(t0);
        expect_ev(S_Y, 0, t0 + 13);
        expect_ev(S_AR, 0, t0 + 25);
        expect_ev(S_G, 1, t0 + 29);
        expect_ev(S_Y, 1, t0 + 110);
        expect_ev(S_AR, 1, t0 + 122);
        expect_ev(S_G, 0, t0 + 126);
        wait_until(t0 + 12);
        preempt = 1'b1;
        preempt_phase = 2'd1;
        wait_until(t0 + 89);
        check("preempt_hold_sec", sec_elapsed, 15);
        preempt = 1'b0;
        finish_scn(t0 + 130);
`endif

        check("safety", safety_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
